// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the sequential N-by-M divider.
//   state_t  : FSM encodings S_IDLE, S_CHECK, S_STEP, S_DONE (2 bits wide)
//   clog2()  : counter width helper, used as clog2(K+1) so the counter can hold K
package divider_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Smallest width w (at least 1) such that 2**w >= v.
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/div_step_unit.sv
// div_step_unit: one combinational restoring-division step.
//   t      in  M+1  trial value {R, next dividend bit}
//   y      in  M    divisor
//   r_next out M    remainder after the step (t-y if t>=y, else t)
//   q_bit  out 1    1 when t >= y
// The feasibility check reuses this unit with t = {1'b0, R}, so q_bit
// then reads as "R >= Y".
module div_step_unit #(
  parameter int M = 4
) (
  input  logic [M:0]   t,
  input  logic [M-1:0] y,
  output logic [M-1:0] r_next,
  output logic         q_bit
);

  always_comb begin
    q_bit  = (t >= {1'b0, y});
    // When t >= y the true difference is < y, so it fits in M bits and the
    // low M bits of the modular subtraction are exact.
    r_next = q_bit ? (t[M-1:0] - y) : t[M-1:0];
  end

endmodule

// File: rtl/seq_nbym_divider.sv
// seq_nbym_divider: radix-2 restoring divider, one quotient bit per clock.
//   clock   in  1    rising-edge clock
//   reset_  in  1    synchronous active-low reset
//   soc     in  1    start of conversion, honoured only in IDLE
//   x       in  N    dividend, captured on the accepting edge
//   y       in  M    divisor, captured on the accepting edge
//   eoc     out 1    1 = idle or result valid, 0 = busy
//   q       out N-M  quotient
//   r       out M    remainder
//   no_div  out 1    1 = last operation infeasible (overflow or y == 0)
module seq_nbym_divider
  import divider_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           soc,
  input  logic [N-1:0]   x,
  input  logic [M-1:0]   y,
  output logic           eoc,
  output logic [N-M-1:0] q,
  output logic [M-1:0]   r,
  output logic           no_div
);

  localparam int K  = N - M;
  localparam int CW = clog2(K + 1);

  state_t         state_q, state_d;
  logic [M-1:0]   part_q, part_d;     // partial remainder R
  logic [K-1:0]   dsr_q, dsr_d;       // remaining dividend bits, MSB first
  logic [M-1:0]   y_q, y_d;
  logic [K-1:0]   quo_q, quo_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           no_div_q, no_div_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [M:0]     step_t;
  logic [M-1:0]   step_r;
  logic           step_bit;

  // CHECK compares R against Y alone; STEP brings in the next dividend bit.
  assign step_t = (state_q == S_CHECK) ? {1'b0, part_q} : {part_q, dsr_q[K-1]};

  div_step_unit #(.M(M)) u_step (
    .t      (step_t),
    .y      (y_q),
    .r_next (step_r),
    .q_bit  (step_bit)
  );

  always_comb begin
    state_d  = state_q;
    part_d   = part_q;
    dsr_d    = dsr_q;
    y_d      = y_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    no_div_d = no_div_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (soc) begin
          part_d   = x[N-1:K];
          dsr_d    = x[K-1:0];
          y_d      = y;
          quo_d    = '0;
          rem_d    = '0;
          no_div_d = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        // R >= Y means the quotient would not fit in K bits (or Y == 0).
        if (step_bit) begin
          no_div_d = 1'b1;
          quo_d    = '0;
          rem_d    = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d   = CW'(K);
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        part_d = step_r;
        quo_d  = (quo_q << 1) | K'(step_bit);
        dsr_d  = dsr_q << 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rem_d   = step_r;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A held soc must not retrigger; require it to drop first.
        if (!soc) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q  <= S_IDLE;
      part_q   <= '0;
      dsr_q    <= '0;
      y_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      no_div_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      part_q   <= part_d;
      dsr_q    <= dsr_d;
      y_q      <= y_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      no_div_q <= no_div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign eoc    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign q      = quo_q;
  assign r      = rem_q;
  assign no_div = no_div_q;

endmodule

// File: tb/tb_seq_nbym_divider.sv
module tb_seq_nbym_divider;

  logic       clock;
  logic       reset_;
  logic       soc8, soc16;
  logic [7:0] x8;
  logic [3:0] y8;
  logic       eoc8, nodiv8;
  logic [3:0] q8, r8;
  logic [15:0] x16;
  logic [7:0]  y16;
  logic        eoc16, nodiv16;
  logic [7:0]  q16, r16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  got8;
  logic [17:0] got16;

  seq_nbym_divider #(.N(8), .M(4)) dut8 (
    .clock(clock), .reset_(reset_), .soc(soc8), .x(x8), .y(y8),
    .eoc(eoc8), .q(q8), .r(r8), .no_div(nodiv8)
  );

  seq_nbym_divider #(.N(16), .M(8)) dut16 (
    .clock(clock), .reset_(reset_), .soc(soc16), .x(x16), .y(y16),
    .eoc(eoc16), .q(q16), .r(r16), .no_div(nodiv16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign got8  = {eoc8, nodiv8, q8, r8};
  assign got16 = {eoc16, nodiv16, q16, r16};

  // Accept a run on dut8: leaves us at the falling edge after edge 0.
  task automatic start8(input logic [7:0] xv, input logic [3:0] yv, input bit hold);
    @(posedge clock);
    @(negedge clock);
    x8 = xv; y8 = yv; soc8 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (!hold) soc8 = 1'b0;
    x8 = ~xv; y8 = ~yv;  // operands may change freely after acceptance
  endtask

  task automatic start16(input logic [15:0] xv, input logic [7:0] yv);
    @(posedge clock);
    @(negedge clock);
    x16 = xv; y16 = yv; soc16 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    soc16 = 1'b0;
  endtask

  // Feasible run on dut8: busy through edge 4, result after edge 5.
  task automatic feasible8(input string name, input logic [7:0] xv, input logic [3:0] yv,
                           input logic [3:0] eq, input logic [3:0] er);
    start8(xv, yv, 1'b0);
    n_cmp++;
    if (eoc8 !== 1'b0) begin n_bad++; $display("FAIL %s_busy: eoc=%b want 0", name, eoc8); end
    repeat (4) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (eoc8 !== 1'b0) begin n_bad++; $display("FAIL %s_edge4: eoc=%b want 0", name, eoc8); end
    @(posedge clock);
    @(negedge clock);
    $display("txn %s: x=%0d y=%0d -> eoc=%b no_div=%b q=%0d r=%0d", name, xv, yv, eoc8, nodiv8, q8, r8);
    n_cmp++;
    if (got8 !== {1'b1, 1'b0, eq, er}) begin
      n_bad++;
      $display("FAIL %s_result: eoc/no_div/q/r=%b/%b/%0d/%0d want 1/0/%0d/%0d", name, eoc8, nodiv8, q8, r8, eq, er);
    end
  endtask

  task automatic infeasible8(input string name, input logic [7:0] xv, input logic [3:0] yv);
    start8(xv, yv, 1'b0);
    @(posedge clock);
    @(negedge clock);
    $display("txn %s: x=%0d y=%0d -> eoc=%b no_div=%b q=%0d r=%0d", name, xv, yv, eoc8, nodiv8, q8, r8);
    n_cmp++;
    if (got8 !== 10'b1_1_0000_0000) begin
      n_bad++;
      $display("FAIL %s_nodiv: eoc/no_div/q/r=%b/%b/%0d/%0d want 1/1/0/0", name, eoc8, nodiv8, q8, r8);
    end
  endtask

  task automatic test_reset;
    reset_ = 1'b0; soc8 = 1'b0; soc16 = 1'b0;
    x8 = '0; y8 = '0; x16 = '0; y16 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    $display("txn reset: eoc=%b no_div=%b q=%0d r=%0d", eoc8, nodiv8, q8, r8);
    n_cmp++;
    if (got8 !== 10'b1_0_0000_0000) begin
      n_bad++; $display("FAIL reset8: got %b want 1000000000", got8);
    end
    n_cmp++;
    if (got16 !== {2'b10, 16'h0000}) begin
      n_bad++; $display("FAIL reset16: got %h want 20000", got16);
    end
    reset_ = 1'b1;
  endtask

  task automatic test_feasible;
    feasible8("div_200_13", 8'd200, 4'd13, 4'd15, 4'd5);
    feasible8("div_15_1",   8'd15,  4'd1,  4'd15, 4'd0);
    feasible8("div_0_7",    8'd0,   4'd7,  4'd0,  4'd0);
  endtask

  task automatic test_infeasible;
    infeasible8("div_100_0",  8'd100, 4'd0);
    infeasible8("div_208_13", 8'd208, 4'd13);
  endtask

  task automatic test_held_soc;
    start8(8'd200, 4'd13, 1'b1);
    repeat (5) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (got8 !== {2'b10, 4'd15, 4'd5}) begin
      n_bad++; $display("FAIL held_result: got %b want 1011110101", got8);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    $display("txn held_soc: eoc=%b no_div=%b q=%0d r=%0d", eoc8, nodiv8, q8, r8);
    n_cmp++;
    if (got8 !== {2'b10, 4'd15, 4'd5}) begin
      n_bad++; $display("FAIL held_stable: got %b want 1011110101", got8);
    end
    soc8 = 1'b0;
    // 50 >= 3*16, so the quotient overflows 4 bits.
    infeasible8("div_50_3", 8'd50, 4'd3);
    feasible8("div_50_4", 8'd50, 4'd4, 4'd12, 4'd2);
  endtask

  task automatic test_reset_midrun;
    start8(8'd200, 4'd13, 1'b0);
    repeat (3) @(posedge clock);   // edges 1..3 (CHECK, first two STEPs)
    @(negedge clock);
    reset_ = 1'b0;
    @(posedge clock);               // edge 4: third STEP edge
    @(negedge clock);
    $display("txn reset_midrun: eoc=%b no_div=%b q=%0d r=%0d", eoc8, nodiv8, q8, r8);
    n_cmp++;
    if (got8 !== 10'b1_0_0000_0000) begin
      n_bad++; $display("FAIL midrun_reset: got %b want 1000000000", got8);
    end
    reset_ = 1'b1;
    feasible8("after_reset", 8'd200, 4'd13, 4'd15, 4'd5);
  endtask

  task automatic test_wide;
    start16(16'd65279, 8'd255);
    repeat (8) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (eoc16 !== 1'b0) begin n_bad++; $display("FAIL wide_edge8: eoc=%b want 0", eoc16); end
    @(posedge clock);
    @(negedge clock);
    $display("txn wide_65279_255: eoc=%b no_div=%b q=%0d r=%0d", eoc16, nodiv16, q16, r16);
    n_cmp++;
    if (got16 !== {2'b10, 8'd255, 8'd254}) begin
      n_bad++; $display("FAIL wide_result: got q=%0d r=%0d eoc=%b no_div=%b want 255/254/1/0", q16, r16, eoc16, nodiv16);
    end
    start16(16'd65535, 8'd255);
    @(posedge clock);
    @(negedge clock);
    $display("txn wide_65535_255: eoc=%b no_div=%b q=%0d r=%0d", eoc16, nodiv16, q16, r16);
    n_cmp++;
    if (got16 !== {2'b11, 16'h0000}) begin
      n_bad++; $display("FAIL wide_nodiv: got q=%0d r=%0d eoc=%b no_div=%b want 0/0/1/1", q16, r16, eoc16, nodiv16);
    end
  endtask

  initial begin
    test_reset();
    test_feasible();
    test_infeasible();
    test_held_soc();
    test_reset_midrun();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
